// File: rtl/arm_imm_pkg.sv
// arm_imm_pkg: shared types and sizes for the ARM rotated-immediate encoder.
package arm_imm_pkg;
    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
    localparam int ROT_COUNT = 16;
    localparam int ROT_W     = 4;
    localparam int IMM8_W    = 8;
    localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROT_COUNT - 1);
endpackage

// File: rtl/imm_rot_check.sv
// imm_rot_check: tests one rotation of a 32-bit candidate for an imm8 fit.
// Ports:
//   operand [31:0] in  - value under test
//   rot     [3:0]  in  - rotation index r; operand is rotated left by 2*r
//   match          out - rotated value has its upper 24 bits clear
//   imm8    [7:0]  out - low byte of the rotated value
module imm_rot_check
    import arm_imm_pkg::*;
(
    input  logic [31:0]       operand,
    input  logic [ROT_W-1:0]  rot,
    output logic              match,
    output logic [IMM8_W-1:0] imm8
);
    logic [5:0]  sh;
    logic [31:0] c;
    assign sh = {1'b0, rot, 1'b0};
    // sh=0 gives a 32-bit right shift, which yields 0 and leaves c = operand
    assign c = (operand << sh) | (operand >> (6'd32 - sh));
    assign match = c[31:IMM8_W] == '0;
    assign imm8 = c[IMM8_W-1:0];
endmodule

// File: rtl/imm_rot_encoder.sv
// imm_rot_encoder: searches for the ARM rotated-immediate form of a 32-bit constant.
// Ports:
//   clk, rst_n (async, active-low)
//   start, value[31:0]   - request; accepted only in IDLE
//   busy                 - high in SEARCH and DONE
//   done                 - one-cycle pulse when results are valid
//   valid                - constant is encodable
//   shift_operand[11:0]  - {rotate_imm, imm8}, operand2 = imm8 ROR (2*rotate_imm)
//   inverted             - encoding is for ~value (MVN form)
// Macro IMM_ROT_ENCODER_MVN_EN enables a second search pass on ~value.
module imm_rot_encoder
    import arm_imm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [11:0] shift_operand,
    output logic        inverted
);
    state_t             state, state_d;
    logic [31:0]        value_q;
    logic [ROT_W-1:0]   r;
    logic [IMM8_W-1:0]  imm8;
    logic               pass, more, match, accept;

    assign accept = state == IDLE && start;
    assign busy   = state != IDLE;
    assign done   = state == DONE;

    imm_rot_check u_check (
        .operand (pass ? ~value_q : value_q),
        .rot     (r),
        .match   (match),
        .imm8    (imm8)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = start ? SEARCH : IDLE;
            SEARCH:  state_d = (match || (r == ROT_LAST && !more)) ? DONE : SEARCH;
            default: state_d = IDLE;
        endcase
    end

    // Results are cleared on accept, so a failed search simply leaves them at 0.
    // r wraps from ROT_LAST to 0 on its own, which starts the MVN pass at r=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q       <= '0;
            r             <= '0;
            valid         <= 1'b0;
            shift_operand <= '0;
        end else if (accept) begin
            value_q       <= value;
            r             <= '0;
            valid         <= 1'b0;
            shift_operand <= '0;
        end else if (state == SEARCH) begin
            if (match) begin
                valid         <= 1'b1;
                shift_operand <= {r, imm8};
            end
            r <= r + 1'b1;
        end
    end

`ifdef IMM_ROT_ENCODER_MVN_EN
    assign more = ~pass;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass     <= 1'b0;
            inverted <= 1'b0;
        end else if (accept) begin
            pass     <= 1'b0;
            inverted <= 1'b0;
        end else if (state == SEARCH) begin
            if (match)              inverted <= pass;
            else if (r == ROT_LAST) pass     <= 1'b1;
        end
    end
`else
    assign pass     = 1'b0;
    assign more     = 1'b0;
    assign inverted = 1'b0;
`endif
endmodule

// File: tb/tb_imm_rot_encoder.sv
// tb_imm_rot_encoder: randomized self-checking bench with a round-trip reference model.
module tb_imm_rot_encoder;
`ifdef IMM_ROT_ENCODER_MVN_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] value;
    logic        busy, done, valid, inverted;
    logic [11:0] shift_operand;
    int          n_checks = 0;
    int          n_pass = 0;

    imm_rot_encoder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .value         (value),
        .busy          (busy),
        .done          (done),
        .valid         (valid),
        .shift_operand (shift_operand),
        .inverted      (inverted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return n == 0 ? x : (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return n == 0 ? x : (x >> n) | (x << (32 - n));
    endfunction

    // Finds the smallest (pass, rotation) whose imm8 rotated right reproduces the target.
    task automatic model(input logic [31:0] v, output int lat, output logic vld,
                         output logic [11:0] op, output logic inv);
        logic [31:0] t, w;
        logic [7:0]  imm;
        bit          found;
        lat = 16 * NPASS + 1; vld = 0; op = '0; inv = 0; found = 0;
        for (int p = 0; p < NPASS; p++)
            for (int k = 0; k < 16; k++) begin
                t = p == 1 ? ~v : v;
                w = rotl(t, 2 * k);
                imm = w[7:0];
                if (!found && rotr({24'b0, imm}, 2 * k) == t) begin
                    found = 1; lat = 16 * p + k + 2; vld = 1;
                    op = {4'(k), imm}; inv = p[0];
                end
            end
    endtask

    task automatic run(input logic [31:0] v, input bit noisy);
        int          lat, cyc;
        logic        vld, inv;
        logic [11:0] op;
        model(v, lat, vld, op, inv);
        start = 1'b1; value = v;
        @(posedge clk); #1;
        cyc = 1;
        if (noisy) value = 32'h1; else start = 1'b0;
        check("clr_valid", 32'(valid), 32'(1'b0));
        check("clr_op", 32'(shift_operand), 32'(12'h0));
        check("busy_search", 32'(busy), 32'(1'b1));
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'(lat));
        check("valid", 32'(valid), 32'(vld));
        check("operand", 32'(shift_operand), 32'(op));
        check("inverted", 32'(inverted), 32'(inv));
        @(posedge clk); #1;
        check("done_pulse", 32'(done), 32'(1'b0));
        check("idle", 32'(busy), 32'(1'b0));
        check("hold_op", 32'(shift_operand), 32'(op));
        check("hold_valid", 32'(valid), 32'(vld));
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        rst_n = 1'b0; start = 1'b0; value = '0;
        #1;
        check("rst_busy", 32'(busy), 32'(1'b0));
        check("rst_done", 32'(done), 32'(1'b0));
        check("rst_valid", 32'(valid), 32'(1'b0));
        check("rst_op", 32'(shift_operand), 32'(12'h0));
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        run(32'h000000FF, 0);
        run(32'hFF000000, 0);
        run(32'h00000102, 0);
        run(32'hFFFFFF00, 0);
        run(32'h000003FC, 1);
        run(32'hF000000F, 0);
        // abort a long search with an async reset mid-cycle
        start = 1'b1; value = 32'h00000102;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0; #1;
        check("arst_busy", 32'(busy), 32'(1'b0));
        check("arst_done", 32'(done), 32'(1'b0));
        check("arst_valid", 32'(valid), 32'(1'b0));
        check("arst_op", 32'(shift_operand), 32'(12'h0));
        check("arst_inv", 32'(inverted), 32'(1'b0));
        repeat (3) begin
            @(posedge clk); #1;
            check("arst_nodone", 32'(done), 32'(1'b0));
        end
        @(negedge clk) rst_n = 1'b1;
        run(32'h000003FC, 0);
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0:       v = $urandom;
                1:       v = rotr({24'b0, 8'($urandom)}, 2 * int'($urandom_range(0, 15)));
                default: v = ~rotr({24'b0, 8'($urandom)}, 2 * int'($urandom_range(0, 15)));
            endcase
            run(v, $urandom_range(0, 3) == 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/imm_rot_encoder.md
IMM_ROT_ENCODER -- requirements
Module: imm_rot_encoder

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have port: start  input  1  request to encode value; sampled only in IDLE.
REQ-004 SHALL have port: value  input  32  constant to encode; captured on accepted start.
REQ-005 SHALL have port: busy  output  1  high in SEARCH and DONE.
REQ-006 SHALL have port: done  output  1  one-cycle pulse; the result fields are valid this cycle.
REQ-007 SHALL have port: valid  output  1  1 = constant is encodable as an ARM rotated immediate.
REQ-008 SHALL have port: shift_operand  output  12  [11:8] rotate_imm, [7:0] imm8; operand2 = imm8 ROR (2*rotate_imm).
REQ-009 SHALL have port: inverted  output  1  1 = encoding is for ~value (MVN form).

Function
REQ-010 SHALL implement the states IDLE, SEARCH and DONE.
REQ-011 In IDLE with start=1, SHALL capture value, set rotation counter r=0 and pass=0, and move to SEARCH.
REQ-012 In each SEARCH cycle, SHALL test candidate c = (pass ? ~value_q : value_q) ROL (2*r); a match means c[31:8]==0.
REQ-013 On a match, SHALL latch shift_operand={r[3:0],c[7:0]}, valid=1 and inverted=pass, and go to DONE.
REQ-014 SHALL test exactly one rotation per cycle, r ascending 0..15; the first (smallest r) match wins.
REQ-015 If there is no match at r=15 and no further pass is enabled, SHALL latch valid=0, shift_operand=0 and inverted=0, and go to DONE.
REQ-016 In DONE, SHALL assert done for one cycle and then return to IDLE unconditionally.
REQ-017 Latency: with start accepted at edge 0, a match at rotation k of pass p SHALL give done high in cycle 16*p+k+2; failure on all passes SHALL give done at cycle 17 (one pass) or 33 (two passes).
REQ-018 SHALL ignore start while busy=1; a start in the DONE cycle is also ignored.
REQ-019 valid, shift_operand and inverted SHALL hold their last result from DONE until the next accepted start.
REQ-020 On the cycle after an accepted start, valid, shift_operand and inverted SHALL read as 0.
REQ-021 A change of value after start is accepted SHALL have no effect on the search in progress.

Reset
REQ-022 rst_n=0 SHALL immediately force IDLE, r=0 and pass=0, and set busy, done, valid, shift_operand and inverted to 0, including mid-search.
REQ-023 After rst_n deasserts, a start in the first clk cycle SHALL be accepted normally.

Configuration
REQ-024 The macro IMM_ROT_ENCODER_MVN_EN SHALL select the MVN fallback.
REQ-025 With IMM_ROT_ENCODER_MVN_EN defined: when pass 0 fails at r=15, the block SHALL set pass=1 and r=0 and stay in SEARCH for a second 16-rotation pass on ~value_q.
REQ-026 Without IMM_ROT_ENCODER_MVN_EN: only pass 0 SHALL run, inverted SHALL be constant 0, and the port SHALL remain present.

Structure
REQ-027 The shared package arm_imm_pkg SHALL hold the state enum (IDLE/SEARCH/DONE), ROT_COUNT=16, ROT_W=4 and IMM8_W=8.
REQ-028 The combinational test (rotate-left by 2*r, upper-24-zero check, imm8 extract) SHALL be the sub-module imm_rot_check, instantiated once.
REQ-029 Output decoding of {rotate_imm, imm8} SHALL round-trip through the team's operand2 generator to the original value (or to ~value when inverted=1).

Verification
REQ-030 value=0x000000FF -> done at cycle 2, valid=1, shift_operand=0x0FF, inverted=0.
REQ-031 value=0xFF000000 -> done at cycle 6, valid=1, shift_operand=0x4FF; r=1..3 must not match.
REQ-032 value=0x00000102 -> done at cycle 17 without the macro (33 with it), valid=0, shift_operand=0x000.
REQ-033 value=0xFFFFFF00 -> with the macro: done at cycle 18, valid=1, inverted=1, shift_operand=0x0FF; without the macro: done at cycle 17, valid=0.
REQ-034 Start accepted, rst_n pulsed low at cycle 5, then released -> all outputs 0 at once, state IDLE, no done pulse; the next start with 0x3FC -> done at cycle 17, shift_operand=0xFFF (0xFF ROR 30).
REQ-035 Start re-asserted every cycle during a search with value changed to 0x1 -> the first result is unchanged, exactly one done pulse, and the new request is accepted only from IDLE.
